// File: rtl/axis_write_packetizer.sv
// AXI-Stream write feed for the s02 slave: buffers input beats, zero-fills partial strobes,
// and caps packets at PKT_LEN beats before a registered output stage.
module axis_write_packetizer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PKT_LEN    = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    s01_axis_aclk,
  input  logic                    s01_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic [CNT_WIDTH-1:0]    fill_count
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned AddrWidth = $clog2(FIFO_DEPTH);

  typedef enum logic {StEmpty, StFull} stage_e;

  logic [DATA_WIDTH:0]  mem_q [FIFO_DEPTH];
  logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrWidth:0]   occ_q;
  logic [15:0]          beat_cnt_q;
  stage_e               stage_q, stage_d;
  logic [DATA_WIDTH-1:0] stage_data_q;
  logic [StrbWidth-1:0]  stage_strb_q;
  logic                  stage_last_q;
  logic [CNT_WIDTH-1:0]  pkt_count_q, fill_count_q;

  logic                  fifo_full, fifo_empty, push, pop, out_fire, last_in, partial;
  logic [DATA_WIDTH-1:0] filled_data;

  assign fifo_full       = (occ_q == (AddrWidth+1)'(FIFO_DEPTH));
  assign fifo_empty      = (occ_q == '0);
  assign s01_axis_tready = s01_axis_aresetn && !fifo_full;
  assign push            = s01_axis_tvalid && s01_axis_tready;
  assign out_fire        = m01_axis_tvalid && m01_axis_tready;
  assign pop             = !fifo_empty && ((stage_q == StEmpty) || out_fire);
  assign partial         = (s01_axis_tstrb != '1);
  assign last_in         = s01_axis_tlast || (beat_cnt_q == 16'(PKT_LEN - 1));

  always_comb begin
    filled_data = '0;
    for (int i = 0; i < int'(StrbWidth); i++) begin
      filled_data[8*i +: 8] = s01_axis_tstrb[i] ? s01_axis_tdata[8*i +: 8] : 8'h00;
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge s01_axis_aclk) begin
    if (push) mem_q[wr_ptr_q] <= {filled_data, last_in};
  end

  always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
    if (!s01_axis_aresetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      beat_cnt_q   <= '0;
      fill_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + AddrWidth'(1);
        beat_cnt_q <= last_in ? 16'd0 : beat_cnt_q + 16'd1;
        if (partial) fill_count_q <= fill_count_q + CNT_WIDTH'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + (AddrWidth+1)'(1);
        2'b01:   occ_q <= occ_q - (AddrWidth+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Output stage: state register
  always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
    if (!s01_axis_aresetn) stage_q <= StEmpty;
    else                   stage_q <= stage_d;
  end

  // Output stage: next state
  always_comb begin
    stage_d = stage_q;
    unique case (stage_q)
      StEmpty: if (pop) stage_d = StFull;
      StFull:  if (out_fire && !pop) stage_d = StEmpty;
      default: stage_d = StEmpty;
    endcase
  end

  // Output stage: outputs
  always_comb begin
    m01_axis_tvalid = (stage_q == StFull);
    m01_axis_tdata  = stage_data_q;
    m01_axis_tstrb  = stage_strb_q;
    m01_axis_tlast  = stage_last_q;
  end

  always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
    if (!s01_axis_aresetn) begin
      stage_data_q <= '0;
      stage_strb_q <= '0;
      stage_last_q <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      if (pop) begin
        {stage_data_q, stage_last_q} <= mem_q[rd_ptr_q];
        stage_strb_q                 <= '1;
      end
      if (out_fire && m01_axis_tlast) pkt_count_q <= pkt_count_q + CNT_WIDTH'(1);
    end
  end

  assign pkt_count  = pkt_count_q;
  assign fill_count = fill_count_q;

endmodule

// File: tb/tb_axis_write_packetizer.sv
// Directed bench for axis_write_packetizer: ordering, packet capping, strobe fill,
// backpressure, async reset and randomised output stalls.
module tb_axis_write_packetizer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [15:0] pkt_count;
  logic [15:0] fill_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] out_q[$];
  logic [32:0] exp_q[$];
  bit          stim_done;

  always #5 aclk = ~aclk;

  axis_write_packetizer #(
    .DATA_WIDTH(32), .FIFO_DEPTH(8), .PKT_LEN(16), .CNT_WIDTH(16)
  ) dut (
    .s01_axis_aclk   (aclk),
    .s01_axis_aresetn(aresetn),
    .s01_axis_tdata  (s_tdata),
    .s01_axis_tstrb  (s_tstrb),
    .s01_axis_tvalid (s_tvalid),
    .s01_axis_tlast  (s_tlast),
    .s01_axis_tready (s_tready),
    .m01_axis_tdata  (m_tdata),
    .m01_axis_tstrb  (m_tstrb),
    .m01_axis_tvalid (m_tvalid),
    .m01_axis_tlast  (m_tlast),
    .m01_axis_tready (m_tready),
    .pkt_count       (pkt_count),
    .fill_count      (fill_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: records handshakes and checks hold-while-stalled.
  initial begin
    bit          stalled = 0;
    logic [32:0] held = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          check("hold_valid", 64'(m_tvalid), 64'd1);
          check("hold_data", 64'({m_tlast, m_tdata}), 64'(held));
        end
        if (m_tvalid && m_tready) begin
          check("out_strb", 64'(m_tstrb), 64'hF);
          out_q.push_back({m_tlast, m_tdata});
        end
        stalled = m_tvalid && !m_tready;
        held    = {m_tlast, m_tdata};
      end
    end
  end

  task automatic do_reset(input logic rdy);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = rdy;
    aresetn  = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    out_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    s_tdata  = d;
    s_tstrb  = s;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!s_tready) check("send_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int c = 0;
    while (out_q.size() < n && c < budget) begin
      @(posedge aclk);
      #2;
      c++;
    end
    if (out_q.size() < n) check("out_timeout", 64'(out_q.size()), 64'(n));
    @(posedge aclk);
    #2;
  endtask

  initial begin
    int acc;
    logic [31:0] d;

    // 1: 20 full beats, packet capped at 16
    aresetn = 1'b0;
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tready", 64'(s_tready), 64'd0);
    do_reset(1'b1);
    check("rst_pkt", 64'(pkt_count), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    for (int i = 1; i <= 20; i++) send(32'(i), 4'hF, 1'b0);
    wait_out(20, 100);
    check("t1_count", 64'(out_q.size()), 64'd20);
    for (int i = 0; i < 20 && i < out_q.size(); i++)
      check("t1_beat", 64'(out_q[i]), 64'({(i == 15), 32'(i + 1)}));
    check("t1_pkt", 64'(pkt_count), 64'd1);
    check("t1_fill", 64'(fill_count), 64'd0);

    // 2: partial strobe is zero-filled
    do_reset(1'b1);
    send(32'hAABBCCDD, 4'b0101, 1'b1);
    wait_out(1, 20);
    check("t2_beat", 64'(out_q.size() > 0 ? out_q[0] : 33'h0), 64'({1'b1, 32'h00BB00DD}));
    check("t2_fill", 64'(fill_count), 64'd1);
    check("t2_pkt", 64'(pkt_count), 64'd1);

    // 3: backpressure, capacity is depth + 1
    do_reset(1'b0);
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      s_tdata  = 32'(100 + acc);
      s_tstrb  = 4'hF;
      s_tvalid = 1'b1;
      @(negedge aclk);
      if (s_tready) acc++;
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0;
    check("t3_accepted", 64'(acc), 64'd9);
    check("t3_tready", 64'(s_tready), 64'd0);
    check("t3_head", 64'(m_tdata), 64'd100);
    check("t3_valid", 64'(m_tvalid), 64'd1);
    m_tready = 1'b1;
    repeat (9) @(posedge aclk);
    #2;
    check("t3_drained", 64'(m_tvalid), 64'd0);
    check("t3_count", 64'(out_q.size()), 64'd9);
    for (int i = 0; i < 9 && i < out_q.size(); i++)
      check("t3_beat", 64'(out_q[i][31:0]), 64'(100 + i));
    check("t3_tready_back", 64'(s_tready), 64'd1);

    // 4: early input tlast restarts the beat counter
    do_reset(1'b1);
    for (int i = 1; i <= 21; i++) send(32'(i), 4'hF, (i == 5));
    wait_out(21, 100);
    for (int i = 0; i < 21 && i < out_q.size(); i++)
      check("t4_beat", 64'(out_q[i]), 64'({(i == 4 || i == 20), 32'(i + 1)}));
    check("t4_pkt", 64'(pkt_count), 64'd2);

    // 5: async reset mid-packet
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) send(32'(i), 4'h3, 1'b0);
    check("t5_pre_valid", 64'(m_tvalid), 64'd1);
    check("t5_pre_fill", 64'(fill_count), 64'd4);
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check("t5_async_valid", 64'(m_tvalid), 64'd0);
    check("t5_async_fill", 64'(fill_count), 64'd0);
    check("t5_async_tready", 64'(s_tready), 64'd0);
    do_reset(1'b1);
    send(32'h55, 4'hF, 1'b0);
    wait_out(1, 20);
    check("t5_count", 64'(out_q.size()), 64'd1);
    check("t5_first", 64'(out_q.size() > 0 ? out_q[0] : 33'h0), 64'({1'b0, 32'h55}));
    check("t5_pkt", 64'(pkt_count), 64'd0);

    // 6: random output stalls, 500 beats
    do_reset(1'b1);
    exp_q.delete();
    stim_done = 0;
    fork
      begin
        for (int i = 0; i < 500; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge aclk);
            #1;
          end
          d = $urandom;
          exp_q.push_back({(i % 16 == 15), d});
          send(d, 4'hF, 1'b0);
        end
        stim_done = 1;
      end
      begin
        while (!stim_done) begin
          m_tready = 1'($urandom_range(0, 1));
          @(posedge aclk);
          #1;
        end
        m_tready = 1'b1;
      end
    join
    wait_out(500, 200);
    check("t6_count", 64'(out_q.size()), 64'd500);
    for (int i = 0; i < 500 && i < out_q.size(); i++)
      check("t6_beat", 64'(out_q[i]), 64'(exp_q[i]));
    check("t6_pkt", 64'(pkt_count), 64'd31);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
